// File: rtl/layer_ctrl_pwr_seq.sv
// layer_ctrl_pwr_seq: layer-controller power sequencer (macro LC_PWR_IDLE_WAIT_EN gates shutdown on LC_IDLE)
module layer_ctrl_pwr_seq #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic SLEEP_REQ,
  input  logic WAKEUP_REQ,
  input  logic LC_IDLE,
  output logic LC_SLEEP,
  output logic LC_RESET,
  output logic LC_ISOLATION,
  output logic PWR_READY
);
  localparam int W_SET = (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) ? 1 : SETTLE_CYCLES;
  localparam logic [3:0] RELOAD = 4'(W_SET - 1);
  localparam logic [2:0] SLEEP    = 3'd0;
  localparam logic [2:0] WAKE_PWR = 3'd1;
  localparam logic [2:0] WAKE_RST = 3'd2;
  localparam logic [2:0] ACTIVE   = 3'd3;
  localparam logic [2:0] DOWN_ISO = 3'd4;
  localparam logic [2:0] DOWN_RST = 3'd5;
  logic [2:0] r_state, w_next;
  logic [3:0] r_cnt, w_cnt;
  logic w_drain;
  logic r_sleep, r_rst, r_iso, r_rdy;
`ifdef LC_PWR_IDLE_WAIT_EN
  assign w_drain = LC_IDLE;
`else
  logic w_unused;
  assign w_unused = LC_IDLE;
  assign w_drain = 1'b1;
`endif
  // next state and settle counter; requests only matter in SLEEP and ACTIVE
  always_comb begin
    w_next = r_state;
    w_cnt = r_cnt;
    case (r_state)
      SLEEP: if (WAKEUP_REQ && !SLEEP_REQ) begin
        w_next = WAKE_PWR;
        w_cnt = RELOAD;
      end
      WAKE_PWR: if (r_cnt == 4'd0) w_next = WAKE_RST; else w_cnt = r_cnt - 4'd1;
      WAKE_RST: w_next = ACTIVE;
      ACTIVE: if (SLEEP_REQ && w_drain) w_next = DOWN_ISO;
      DOWN_ISO: w_next = DOWN_RST;
      default: w_next = SLEEP;
    endcase
  end
  // state, counter and outputs registered together; outputs decoded from the next state
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state <= SLEEP;
      r_cnt <= 4'd0;
      r_sleep <= 1'b1;
      r_rst <= 1'b1;
      r_iso <= 1'b1;
      r_rdy <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_cnt;
      r_sleep <= (w_next == SLEEP);
      r_rst <= (w_next == SLEEP) || (w_next == WAKE_PWR) || (w_next == DOWN_RST);
      r_iso <= (w_next != ACTIVE);
      r_rdy <= (w_next == ACTIVE);
    end
  end
  assign LC_SLEEP = r_sleep;
  assign LC_RESET = r_rst;
  assign LC_ISOLATION = r_iso;
  assign PWR_READY = r_rdy;
endmodule

// File: tb/tb_layer_ctrl_pwr_seq.sv
// tb_layer_ctrl_pwr_seq: directed scoreboard bench for the power sequencer (SETTLE_CYCLES=4)
module tb_layer_ctrl_pwr_seq;
  logic CLK = 1'b0;
  logic RESETn = 1'b1;
  logic SLEEP_REQ = 1'b0;
  logic WAKEUP_REQ = 1'b0;
  logic LC_IDLE = 1'b1;
  logic LC_SLEEP, LC_RESET, LC_ISOLATION, PWR_READY;
  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] q[$];
  localparam logic [3:0] O_SLP = 4'b1110;
  localparam logic [3:0] O_WP  = 4'b0110;
  localparam logic [3:0] O_WR  = 4'b0010;
  localparam logic [3:0] O_ACT = 4'b0001;
  localparam logic [3:0] O_DI  = 4'b0010;
  localparam logic [3:0] O_DR  = 4'b0110;

  layer_ctrl_pwr_seq #(.SETTLE_CYCLES(4)) dut (
    .CLK(CLK), .RESETn(RESETn), .SLEEP_REQ(SLEEP_REQ), .WAKEUP_REQ(WAKEUP_REQ),
    .LC_IDLE(LC_IDLE), .LC_SLEEP(LC_SLEEP), .LC_RESET(LC_RESET),
    .LC_ISOLATION(LC_ISOLATION), .PWR_READY(PWR_READY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: run time limit expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag);
    logic [3:0] exp, got;
    exp = q.pop_front();
    got = {LC_SLEEP, LC_RESET, LC_ISOLATION, PWR_READY};
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step(input logic s, input logic w, input logic idle, input logic [3:0] exp, input string tag);
    SLEEP_REQ = s;
    WAKEUP_REQ = w;
    LC_IDLE = idle;
    q.push_back(exp);
    @(posedge CLK);
    #1;
    chk(tag);
  endtask

  task automatic now(input logic [3:0] exp, input string tag);
    q.push_back(exp);
    chk(tag);
  endtask

  initial begin
    WAKEUP_REQ = 1'b1;
    #2 RESETn = 1'b0;
    #1 now(O_SLP, "async_reset");
    @(posedge CLK); #1 now(O_SLP, "reset_hold_1");
    @(posedge CLK); #1 now(O_SLP, "reset_hold_2");
    RESETn = 1'b1;
    step(0, 1, 1, O_WP, "wake_first_edge");
    for (int i = 1; i < 4; i++) step(0, 0, 1, O_WP, "wake_settle");
    step(0, 0, 1, O_WR, "wake_rst_off");
    step(0, 0, 1, O_ACT, "wake_active");
    for (int i = 0; i < 3; i++) step(0, 0, 1, O_ACT, "active_hold");
    step(1, 0, 1, O_DI, "down_iso");
    step(0, 0, 1, O_DR, "down_rst");
    step(0, 0, 1, O_SLP, "down_sleep");
    for (int i = 0; i < 5; i++) step(1, 1, 1, O_SLP, "both_req_sleep");
    step(0, 1, 1, O_WP, "wake2_start");
    for (int i = 1; i < 4; i++) step(1, 0, 1, O_WP, "wake2_ignore_sleep");
    step(1, 0, 1, O_WR, "wake2_rst_off");
    step(1, 0, 1, O_ACT, "wake2_one_active");
    step(1, 0, 1, O_DI, "wake2_down_iso");
    step(1, 0, 1, O_DR, "wake2_down_rst");
    step(1, 0, 1, O_SLP, "wake2_sleep");
    step(1, 0, 1, O_SLP, "sleep_req_stays");
    step(0, 1, 0, O_WP, "wake3_start");
    for (int i = 1; i < 4; i++) step(0, 0, 0, O_WP, "wake3_settle");
    step(0, 0, 0, O_WR, "wake3_rst_off");
    step(0, 0, 0, O_ACT, "wake3_active");
`ifdef LC_PWR_IDLE_WAIT_EN
    for (int i = 0; i < 8; i++) step(1, 0, 0, O_ACT, "drain_wait");
    step(1, 0, 1, O_DI, "drain_done_iso");
`else
    step(1, 0, 0, O_DI, "no_drain_iso");
`endif
    step(0, 0, 0, O_DR, "wake3_down_rst");
    step(0, 0, 0, O_SLP, "wake3_sleep");
    step(0, 1, 1, O_WP, "wake4_start");
    step(0, 0, 1, O_WP, "wake4_cnt2");
    RESETn = 1'b0;
    #1 now(O_SLP, "midseq_async_reset");
    @(posedge CLK); #1 now(O_SLP, "midseq_reset_hold");
    RESETn = 1'b1;
    step(0, 1, 1, O_WP, "wake5_start");
    for (int i = 1; i < 4; i++) step(0, 0, 1, O_WP, "wake5_full_settle");
    step(0, 0, 1, O_WR, "wake5_rst_off");
    step(0, 0, 1, O_ACT, "wake5_active");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/layer_ctrl_pwr_seq.md
LAYER_CTRL_PWR_SEQ -- requirements
Module: layer_ctrl_pwr_seq

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, sets the power-settle wait in cycles (legal 1..15) between LC_SLEEP falling and LC_RESET falling.
REQ-002 CLK  input  1  the single clock; every state element is clocked on its rising edge.
REQ-003 RESETn  input  1  reset, asynchronous assert, active-low.
REQ-004 SLEEP_REQ  input  1  level request to power the layer controller down; synchronous to CLK.
REQ-005 WAKEUP_REQ  input  1  level request to power the layer controller up; synchronous to CLK.
REQ-006 LC_IDLE  input  1  layer controller quiescent, with no MBus, register-file or memory transaction in flight.
REQ-007 LC_SLEEP  output  1  power-gate control; 1 means the layer controller is unpowered.
REQ-008 LC_RESET  output  1  layer controller reset; 1 means held in reset.
REQ-009 LC_ISOLATION  output  1  drives the isolation stage; 1 (`IO_HOLD) clamps all layer-controller outputs to 0.
REQ-010 PWR_READY  output  1  1 only while the layer controller is powered, out of reset and un-isolated.

Function
REQ-011 The FSM SHALL have six states: SLEEP, WAKE_PWR, WAKE_RST, ACTIVE, DOWN_ISO and DOWN_RST.
REQ-012 All four outputs SHALL be registered, with no combinational path from any input to any output.
REQ-013 In SLEEP, outputs SHALL be LC_SLEEP=1, LC_RESET=1, LC_ISOLATION=1, PWR_READY=0.
REQ-014 SLEEP to WAKE_PWR SHALL occur on an edge where WAKEUP_REQ=1 and SLEEP_REQ=0; LC_SLEEP falls after that edge (edge k).
REQ-015 WAKE_PWR SHALL run a 4-bit down-counter so that LC_RESET falls after edge k+SETTLE_CYCLES (entering WAKE_RST).
REQ-016 WAKE_RST SHALL last exactly one cycle; LC_ISOLATION falls and PWR_READY rises together after edge k+SETTLE_CYCLES+1 (entering ACTIVE).
REQ-017 ACTIVE to DOWN_ISO SHALL occur on an edge where SLEEP_REQ=1 and the drain condition of REQ-026 holds (edge j); LC_ISOLATION rises and PWR_READY falls after edge j.
REQ-018 DOWN_ISO SHALL last one cycle; LC_RESET rises after edge j+1 (entering DOWN_RST).
REQ-019 DOWN_RST SHALL last one cycle; LC_SLEEP rises after edge j+2 (entering SLEEP).
REQ-020 Output ordering SHALL be strict. On wake: sleep off, then reset off, then isolation off. On sleep: isolation on, then reset on, then sleep on. No two of these outputs change on the same edge.
REQ-021 When SLEEP_REQ and WAKEUP_REQ are both 1, SLEEP_REQ SHALL win: SLEEP stays in SLEEP, and ACTIVE proceeds toward sleep.
REQ-022 Requests SHALL be ignored during WAKE_PWR, WAKE_RST, DOWN_ISO and DOWN_RST; a sequence once started always completes, and levels are re-evaluated only in ACTIVE or SLEEP.
REQ-023 The counter SHALL reload to SETTLE_CYCLES-1 on each entry to WAKE_PWR and SHALL never wrap.
REQ-024 SETTLE_CYCLES values outside 1..15 are illegal, and the implementation SHALL clamp them to 1.

Reset
REQ-025 RESETn=0 SHALL force state SLEEP and outputs LC_SLEEP=1, LC_RESET=1, LC_ISOLATION=1, PWR_READY=0 immediately, independent of CLK, including mid-sequence; the counter clears to 0.

Configuration
REQ-026 Macro LC_PWR_IDLE_WAIT_EN controls the drain condition. When defined, ACTIVE leaves only when SLEEP_REQ=1 and LC_IDLE=1, staying in ACTIVE with PWR_READY=1 while LC_IDLE=0. When undefined, LC_IDLE is ignored (port retained, unused) and SLEEP_REQ=1 alone triggers shutdown.

Verification
REQ-027 Reset: hold RESETn=0 with WAKEUP_REQ=1 -> outputs stay 1,1,1,0; after RESETn rises with WAKEUP_REQ=1, LC_SLEEP falls after the first edge.
REQ-028 Wake with SETTLE_CYCLES=4: WAKEUP_REQ pulse sampled at edge 0 -> LC_SLEEP=0 after edge 0, LC_RESET=0 after edge 4, LC_ISOLATION=0 and PWR_READY=1 after edge 5.
REQ-029 Sleep from ACTIVE with LC_IDLE=1: SLEEP_REQ sampled at edge 10 -> LC_ISOLATION=1 and PWR_READY=0 after edge 10, LC_RESET=1 after edge 11, LC_SLEEP=1 after edge 12.
REQ-030 With LC_PWR_IDLE_WAIT_EN defined, SLEEP_REQ=1 and LC_IDLE=0 for 8 cycles -> PWR_READY stays 1 throughout; LC_IDLE rising at edge 8 -> LC_ISOLATION=1 after edge 8. Without the macro, LC_ISOLATION=1 after the first SLEEP_REQ edge.
REQ-031 Simultaneous SLEEP_REQ=1 and WAKEUP_REQ=1 in SLEEP for 5 cycles -> no output change. SLEEP_REQ=1 raised during WAKE_PWR -> the wake sequence completes, one ACTIVE cycle with PWR_READY=1, then the down sequence.
REQ-032 RESETn pulsed low during WAKE_PWR (counter=2) -> all outputs return to 1,1,1,0 asynchronously, and a fresh wake re-waits the full 4 cycles.
